multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum consecutive cycles spent waiting on memReady in one memory state before a fault is raised; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 memReady  input  1  memory handshake; the current read or write completes in a cycle where memReady=1.
REQ-006 pcWrite, pcWriteCond, irWrite, memRead, memWrite, iorD, regWrite, regDst, memToReg, aluSrcA  output  1 each  datapath enables and selects.
REQ-007 aluSrcB, aluOp, pcSource  output  2 each  ALU operand select, ALU op class, and PC source select.
REQ-008 illegalOp, memError  output  1 each  sticky fault flags.
REQ-009 state  output  3  current state encoding, for debug.

Function
REQ-010 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEMACC=4, WB=5, ERROR=7; outputs are Moore, except the memReady-qualified enables in REQ-012 and REQ-015.
REQ-011 IDLE: all outputs SHALL be 0; the next state is FETCH unconditionally.
REQ-012 FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
- irWrite and pcWrite SHALL be 1 only in the cycle memReady=1.
- That cycle transitions to DECODE; otherwise the block stays in FETCH.
REQ-013 DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Next state by opcode:
- 000000 (R), 100011 (lw), 101011 (sw), 001000 (addi), 000100 (beq), 000010 (j) go to EXEC.
- Any other opcode goes to ERROR and sets illegalOp.
REQ-014 EXEC outputs and next state:
- R: aluSrcA=1, aluSrcB=00, aluOp=10; next WB.
- lw, sw, addi: aluSrcA=1, aluSrcB=10, aluOp=00; lw/sw next MEMACC, addi next WB.
- beq: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01; next FETCH.
- j: pcWrite=1, pcSource=10; next FETCH.
REQ-015 MEMACC: iorD=1; memRead=1 for lw, memWrite=1 for sw; held until memReady=1.
- On completion, lw goes to WB and sw goes to FETCH.
REQ-016 WB: regWrite=1 for exactly one full cycle, so the register file's falling-edge write lands mid-cycle; next state FETCH.
- R: regDst=1, memToReg=0.
- lw: regDst=0, memToReg=1.
- addi: regDst=0, memToReg=0.
REQ-017 The opcode SHALL be latched on leaving DECODE; EXEC, MEMACC and WB use the latched copy, not the live input.
REQ-018 Instruction latency with zero memory wait: beq and j take 3 cycles; R, sw and addi take 4; lw takes 5.
REQ-019 Wait counter (8 bits):
- Clears on entry to FETCH or MEMACC.
- Increments each cycle memReady=0 in those states.
- Reaching MEM_TIMEOUT goes to ERROR and sets memError.
- memReady=1 in the same cycle as the limit is reached counts as completion, not a fault.
REQ-020 ERROR: all enables SHALL be 0; the block stays in ERROR until reset.
REQ-021 illegalOp and memError SHALL be sticky; they clear only on reset.

Reset
REQ-022 On rst=1 (asynchronous), the block SHALL set state=IDLE, clear the wait counter, latched opcode and both fault flags, and force all outputs to 0 immediately.
REQ-023 Reset asserted mid-instruction (any state, including MEMACC with memWrite=1) SHALL abort the instruction with no further regWrite or pcWrite.

Structure
REQ-024 The state encodings, opcode constants, and the aluOp and pcSource codes SHALL live in the shared package mips_pkg.
REQ-025 The wait counter SHALL be a sub-module, mem_wait_timer (clear, count, limit, expired).

Verification
REQ-026 R-type with memReady tied to 1: the state sequence SHALL be 0,1,2,3,5,1; regWrite=1 only in the WB cycle, with regDst=1.
REQ-027 lw, with memReady low for 3 cycles in MEMACC: memRead and iorD held 4 cycles; WB has memToReg=1; total 8 cycles from FETCH to the next FETCH.
REQ-028 beq followed by j: pcWriteCond=1 for exactly 1 cycle with pcSource=01, then pcWrite=1 in the j EXEC cycle with pcSource=10.
REQ-029 opcode=111111: DECODE goes to ERROR, illegalOp=1; all enables stay 0 for 20 or more cycles.
REQ-030 MEM_TIMEOUT=4 with memReady=0 in FETCH: ERROR and memError=1 after 4 wait cycles; in a second run memReady=1 on the 4th cycle goes to DECODE with no fault.
REQ-031 rst pulsed asynchronously in MEMACC during sw: memWrite drops before the next clock edge; then IDLE, then FETCH, with flags clear.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multicycle MIPS controller.
//   state_t   - controller state encoding (also exported for debug)
//   OP_*      - instruction opcodes (bits [31:26])
//   ALUOP_*   - ALU operation class driven to the ALU control decoder
//   PCSRC_*   - PC source mux selects
//   SRCB_*    - ALU operand-B mux selects
//   ctrl_t    - bundle of the datapath enables/selects produced each cycle
package mips_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEMACC = 3'd4,
        S_WB     = 3'd5,
        S_ERROR  = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;  // PC + 4 straight from the ALU
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;  // branch target held in ALUOut
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;  // pseudo-direct jump target

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;  // sign-extended imm << 2

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       irWrite;
        logic       memRead;
        logic       memWrite;
        logic       iorD;
        logic       regWrite;
        logic       regDst;
        logic       memToReg;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
    } ctrl_t;

    function automatic logic isLegalOp(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: controller <-> datapath/memory signal bundle.
//   opcode, memReady          - into the controller
//   pcWrite..pcSource         - datapath enables and selects
//   illegalOp, memError       - sticky fault flags
//   state                     - current controller state, for debug
// modport master: the controller; modport slave: the datapath side.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       memReady;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       iorD;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       illegalOp;
    logic       memError;
    logic [2:0] state;

    modport master (
        input  opcode, memReady,
        output pcWrite, pcWriteCond, irWrite, memRead, memWrite, iorD,
               regWrite, regDst, memToReg, aluSrcA, aluSrcB, aluOp, pcSource,
               illegalOp, memError, state
    );

    modport slave (
        output opcode, memReady,
        input  pcWrite, pcWriteCond, irWrite, memRead, memWrite, iorD,
               regWrite, regDst, memToReg, aluSrcA, aluSrcB, aluOp, pcSource,
               illegalOp, memError, state
    );
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts stalled memory cycles.
//   clk, rst  - clock, async active-high reset
//   clear     - zero the count (wins over count)
//   count     - this cycle is a stalled memory cycle
//   limit     - number of stalled cycles that constitutes a timeout
//   expired   - combinational: this stalled cycle is the limit-th one
module mem_wait_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);
    logic [WIDTH-1:0] cnt;
    logic [WIDTH:0]   cntInc;

    // One extra bit so a limit of all-ones can still be reached.
    assign cntInc  = {1'b0, cnt} + (WIDTH+1)'(1);
    assign expired = count && (cntInc >= {1'b0, limit});

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        cnt <= '0;
        else if (clear) cnt <= '0;
        else if (count) cnt <= cntInc[WIDTH-1:0];
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a multicycle MIPS datapath.
//   clk, rst  - clock, async active-high reset
//   bus       - multicycle_control_if.master (opcode/memReady in,
//               datapath controls, fault flags and debug state out)
// Outputs are decoded from the state (and latched opcode), with irWrite and
// pcWrite in FETCH qualified by memReady so the IR and PC update exactly once.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_control_if.master        bus
);
    state_t     state, nextState;
    logic [5:0] opLatched;
    logic       illegalOp, memError;
    logic       inMem, waitClear, waitCount, waitExpired;
    ctrl_t      ctrl;

    assign inMem     = (state == S_FETCH) || (state == S_MEMACC);
    assign waitCount = inMem && !bus.memReady;
    // Any state change clears the counter, so it is zero on entry to FETCH
    // or MEMACC, including the direct MEMACC -> FETCH hop after a store.
    assign waitClear = (nextState != state);

    mem_wait_timer #(.WIDTH(8)) uTimer (
        .clk     (clk),
        .rst     (rst),
        .clear   (waitClear),
        .count   (waitCount),
        .limit   (8'(MEM_TIMEOUT)),
        .expired (waitExpired)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nextState;
    end

    // Opcode latch and sticky fault flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opLatched <= '0;
            illegalOp <= 1'b0;
            memError  <= 1'b0;
        end else begin
            if (state == S_DECODE) begin
                opLatched <= bus.opcode;
                if (!isLegalOp(bus.opcode)) illegalOp <= 1'b1;
            end
            // expired implies memReady=0, so a same-cycle completion never faults
            if (inMem && waitExpired) memError <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:   nextState = S_FETCH;
            S_FETCH: begin
                if (bus.memReady)     nextState = S_DECODE;
                else if (waitExpired) nextState = S_ERROR;
            end
            S_DECODE: nextState = isLegalOp(bus.opcode) ? S_EXEC : S_ERROR;
            S_EXEC: begin
                case (opLatched)
                    OP_LW, OP_SW:  nextState = S_MEMACC;
                    OP_R, OP_ADDI: nextState = S_WB;
                    default:       nextState = S_FETCH;   // beq, j
                endcase
            end
            S_MEMACC: begin
                if (bus.memReady)     nextState = (opLatched == OP_LW) ? S_WB : S_FETCH;
                else if (waitExpired) nextState = S_ERROR;
            end
            S_WB:     nextState = S_FETCH;
            S_ERROR:  nextState = S_ERROR;
            default:  nextState = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALUOP_ADD;
                ctrl.pcSource = PCSRC_ALU;
                ctrl.irWrite  = bus.memReady;
                ctrl.pcWrite  = bus.memReady;
            end
            S_DECODE: begin
                ctrl.aluSrcB = SRCB_BRANCH;
                ctrl.aluOp   = ALUOP_ADD;
            end
            S_EXEC: begin
                case (opLatched)
                    OP_R: begin
                        ctrl.aluSrcA = 1'b1;
                        ctrl.aluSrcB = SRCB_REG;
                        ctrl.aluOp   = ALUOP_FUNCT;
                    end
                    OP_LW, OP_SW, OP_ADDI: begin
                        ctrl.aluSrcA = 1'b1;
                        ctrl.aluSrcB = SRCB_IMM;
                        ctrl.aluOp   = ALUOP_ADD;
                    end
                    OP_BEQ: begin
                        ctrl.aluSrcA     = 1'b1;
                        ctrl.aluSrcB     = SRCB_REG;
                        ctrl.aluOp       = ALUOP_SUB;
                        ctrl.pcWriteCond = 1'b1;
                        ctrl.pcSource    = PCSRC_ALUOUT;
                    end
                    OP_J: begin
                        ctrl.pcWrite  = 1'b1;
                        ctrl.pcSource = PCSRC_JUMP;
                    end
                    default: ;
                endcase
            end
            S_MEMACC: begin
                ctrl.iorD     = 1'b1;
                ctrl.memRead  = (opLatched == OP_LW);
                ctrl.memWrite = (opLatched == OP_SW);
            end
            S_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = (opLatched == OP_R);
                ctrl.memToReg = (opLatched == OP_LW);
            end
            default: ;   // IDLE, ERROR: everything off
        endcase
    end

    assign bus.pcWrite     = ctrl.pcWrite;
    assign bus.pcWriteCond = ctrl.pcWriteCond;
    assign bus.irWrite     = ctrl.irWrite;
    assign bus.memRead     = ctrl.memRead;
    assign bus.memWrite    = ctrl.memWrite;
    assign bus.iorD        = ctrl.iorD;
    assign bus.regWrite    = ctrl.regWrite;
    assign bus.regDst      = ctrl.regDst;
    assign bus.memToReg    = ctrl.memToReg;
    assign bus.aluSrcA     = ctrl.aluSrcA;
    assign bus.aluSrcB     = ctrl.aluSrcB;
    assign bus.aluOp       = ctrl.aluOp;
    assign bus.pcSource    = ctrl.pcSource;
    assign bus.illegalOp   = illegalOp;
    assign bus.memError    = memError;
    assign bus.state       = state;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control with MEM_TIMEOUT=4: a table of instructions
// with hand-computed cycle/enable tallies, hand sequences for the fault and
// reset corners, and a randomized instruction stream checked cycle by cycle
// against a trace generated from the instruction rules.
module tb_multicycle_control;

    localparam int TMO = 4;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if bus();
    multicycle_control #(.MEM_TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [2:0] st;
        logic       pcWrite, pcWriteCond, irWrite, memRead, memWrite, iorD;
        logic       regWrite, regDst, memToReg, aluSrcA;
        logic [1:0] aluSrcB, aluOp, pcSource;
        logic       illegalOp, memError;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        int fw, mw;                       // memReady-low cycles in FETCH / MEMACC
        int lat, rw, pw, pwc, io, jw;     // expected tallies for the instruction
    } vec_t;

    int nChk = 0, nPass = 0;

    obs_t expQ[$];
    logic rdyQ[$];
    logic [5:0] opQ[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st = bus.state;           o.pcWrite = bus.pcWrite;
        o.pcWriteCond = bus.pcWriteCond; o.irWrite = bus.irWrite;
        o.memRead = bus.memRead;    o.memWrite = bus.memWrite;
        o.iorD = bus.iorD;          o.regWrite = bus.regWrite;
        o.regDst = bus.regDst;      o.memToReg = bus.memToReg;
        o.aluSrcA = bus.aluSrcA;    o.aluSrcB = bus.aluSrcB;
        o.aluOp = bus.aluOp;        o.pcSource = bus.pcSource;
        o.illegalOp = bus.illegalOp; o.memError = bus.memError;
        return o;
    endfunction

    function automatic obs_t mk(input logic [2:0] st);
        obs_t o = '0;
        o.st = st;
        return o;
    endfunction

    // Leaves the bench sitting on a falling edge with the DUT in FETCH.
    task automatic doReset();
        #2 rst = 1'b1;
        bus.memReady = 1'b0;
        bus.opcode = 6'd0;
        #1 chk("reset.outputs", 32'(sample()), 32'(mk(3'd0)));
        @(negedge clk);
        rst = 1'b0;
        #1 chk("reset.idle", 32'(sample()), 32'(mk(3'd0)));
        @(negedge clk);
    endtask

    // Drive one instruction, tallying what the DUT does until it is back in FETCH.
    task automatic runDirect(input vec_t v, input int idx);
        int cyc = 0, rw = 0, pw = 0, pwc = 0, io = 0, jw = 0, f = 0, m = 0;
        bit left = 0, done = 0;
        obs_t o;
        while (!done && cyc < 40) begin
            o = sample();
            bus.opcode = (o.st == 3'd2) ? v.op : 6'($urandom);
            case (o.st)
                3'd1:    begin bus.memReady = (f == v.fw); f++; end
                3'd4:    begin bus.memReady = (m == v.mw); m++; end
                default: bus.memReady = 1'($urandom);
            endcase
            #1 o = sample();
            cyc++;
            rw  += int'(o.regWrite);
            pw  += int'(o.pcWrite);
            pwc += int'(o.pcWriteCond && o.pcSource == 2'b01);
            io  += int'(o.iorD);
            jw  += int'(o.pcWrite && o.pcSource == 2'b10);
            if (o.st != 3'd1) left = 1;
            @(negedge clk);
            if (left && bus.state == 3'd1) done = 1;
        end
        chk($sformatf("vec%0d.latency", idx), 32'(cyc), 32'(v.lat));
        chk($sformatf("vec%0d.regWrite", idx), 32'(rw), 32'(v.rw));
        chk($sformatf("vec%0d.pcWrite", idx), 32'(pw), 32'(v.pw));
        chk($sformatf("vec%0d.branch", idx), 32'(pwc), 32'(v.pwc));
        chk($sformatf("vec%0d.iorD", idx), 32'(io), 32'(v.io));
        chk($sformatf("vec%0d.jump", idx), 32'(jw), 32'(v.jw));
    endtask

    function automatic void push(input obs_t o, input logic r, input logic [5:0] op);
        expQ.push_back(o);
        rdyQ.push_back(r);
        opQ.push_back(op);
    endfunction

    // Expected per-cycle trace of one instruction from the instruction rules.
    function automatic void planInstr(input logic [5:0] op, input int fw, input int mw);
        obs_t o;
        for (int i = 0; i <= fw; i++) begin
            o = mk(3'd1); o.memRead = 1'b1; o.aluSrcB = 2'b01;
            o.irWrite = (i == fw); o.pcWrite = (i == fw);
            push(o, i == fw, 6'($urandom));
        end
        o = mk(3'd2); o.aluSrcB = 2'b11;
        push(o, 1'($urandom), op);
        o = mk(3'd3);
        if (op == T_R) begin
            o.aluSrcA = 1'b1; o.aluOp = 2'b10;
        end else if (op == T_LW || op == T_SW || op == T_ADDI) begin
            o.aluSrcA = 1'b1; o.aluSrcB = 2'b10;
        end else if (op == T_BEQ) begin
            o.aluSrcA = 1'b1; o.aluOp = 2'b01; o.pcWriteCond = 1'b1; o.pcSource = 2'b01;
        end else begin
            o.pcWrite = 1'b1; o.pcSource = 2'b10;
        end
        push(o, 1'($urandom), 6'($urandom));
        if (op == T_LW || op == T_SW)
            for (int i = 0; i <= mw; i++) begin
                o = mk(3'd4); o.iorD = 1'b1;
                o.memRead = (op == T_LW); o.memWrite = (op == T_SW);
                push(o, i == mw, 6'($urandom));
            end
        if (op == T_R || op == T_LW || op == T_ADDI) begin
            o = mk(3'd5); o.regWrite = 1'b1;
            o.regDst = (op == T_R); o.memToReg = (op == T_LW);
            push(o, 1'($urandom), 6'($urandom));
        end
    endfunction

    task automatic runPlan();
        obs_t e;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            bus.memReady = rdyQ.pop_front();
            bus.opcode = opQ.pop_front();
            #1 chk($sformatf("rand.cycle st=%0d", e.st), 32'(sample()), 32'(e));
            @(negedge clk);
        end
    endtask

    // From FETCH, walk op through DECODE and EXEC into its first MEMACC cycle.
    task automatic toMem(input logic [5:0] op);
        bus.memReady = 1'b1; bus.opcode = 6'($urandom);
        @(negedge clk);
        bus.opcode = op;
        @(negedge clk);
        bus.opcode = 6'($urandom);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[11];
        obs_t e;
        logic [5:0] legal[6];

        vecs[0]  = '{T_R,    0, 0, 4, 1, 1, 0, 0, 0};
        vecs[1]  = '{T_LW,   0, 0, 5, 1, 1, 0, 1, 0};
        vecs[2]  = '{T_SW,   0, 0, 4, 0, 1, 0, 1, 0};
        vecs[3]  = '{T_ADDI, 0, 0, 4, 1, 1, 0, 0, 0};
        vecs[4]  = '{T_BEQ,  0, 0, 3, 0, 1, 1, 0, 0};
        vecs[5]  = '{T_J,    0, 0, 3, 0, 2, 0, 0, 1};
        vecs[6]  = '{T_LW,   0, 3, 8, 1, 1, 0, 4, 0};
        vecs[7]  = '{T_SW,   2, 1, 7, 0, 1, 0, 2, 0};
        vecs[8]  = '{T_R,    1, 0, 5, 1, 1, 0, 0, 0};
        vecs[9]  = '{T_SW,   0, 3, 7, 0, 1, 0, 4, 0};
        vecs[10] = '{T_ADDI, 3, 0, 7, 1, 1, 0, 0, 0};
        legal = '{T_R, T_LW, T_SW, T_ADDI, T_BEQ, T_J};

        bus.memReady = 1'b0;
        bus.opcode = 6'd0;
        doReset();

        for (int i = 0; i < 11; i++) runDirect(vecs[i], i);

        // Illegal opcode: ERROR with illegalOp, everything off, for 22 cycles.
        doReset();
        bus.memReady = 1'b1; bus.opcode = 6'($urandom);
        @(negedge clk);
        bus.opcode = 6'h3F; bus.memReady = 1'($urandom);
        #1 chk("illegal.decode", 32'(bus.state), 32'd2);
        @(negedge clk);
        e = mk(3'd7); e.illegalOp = 1'b1;
        for (int i = 0; i < 22; i++) begin
            bus.memReady = 1'($urandom); bus.opcode = 6'($urandom);
            #1 chk("illegal.hold", 32'(sample()), 32'(e));
            @(negedge clk);
        end

        // FETCH timeout after TMO stalled cycles.
        doReset();
        for (int i = 0; i < TMO; i++) begin
            bus.memReady = 1'b0;
            #1 chk("tmo.fetch.wait", 32'(bus.state), 32'd1);
            @(negedge clk);
        end
        e = mk(3'd7); e.memError = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.memReady = 1'($urandom);
            #1 chk("tmo.fetch.error", 32'(sample()), 32'(e));
            @(negedge clk);
        end

        // Ready on the TMO-th cycle completes instead of faulting.
        doReset();
        for (int i = 0; i < TMO; i++) begin
            bus.memReady = (i == TMO - 1);
            #1 chk("tmo.edge.irWrite", 32'(bus.irWrite), 32'(i == TMO - 1));
            @(negedge clk);
        end
        bus.opcode = T_R;
        e = mk(3'd2); e.aluSrcB = 2'b11;
        #1 chk("tmo.edge.decode", 32'(sample()), 32'(e));

        // MEMACC timeout during lw.
        doReset();
        toMem(T_LW);
        for (int i = 0; i < TMO; i++) begin
            bus.memReady = 1'b0;
            #1 chk("tmo.mem.read", 32'({bus.state, bus.memRead, bus.iorD}), 32'({3'd4, 2'b11}));
            @(negedge clk);
        end
        e = mk(3'd7); e.memError = 1'b1;
        #1 chk("tmo.mem.error", 32'(sample()), 32'(e));

        // Asynchronous reset while a store is on the bus.
        doReset();
        toMem(T_SW);
        bus.memReady = 1'b0;
        #1 chk("rstmem.memWrite", 32'(bus.memWrite), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rstmem.drop", 32'(sample()), 32'(mk(3'd0)));
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rstmem.idle", 32'(sample()), 32'(mk(3'd0)));
        @(negedge clk);
        e = mk(3'd1); e.memRead = 1'b1; e.aluSrcB = 2'b01;
        #1 chk("rstmem.fetch", 32'(sample()), 32'(e));

        // Random instruction stream against the rule-generated trace.
        doReset();
        for (int n = 0; n < 60; n++)
            planInstr(legal[$urandom_range(0, 5)], int'($urandom_range(0, TMO - 1)),
                      int'($urandom_range(0, TMO - 1)));
        runPlan();

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end
endmodule
